// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decrypt core's plaintext validator.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_REQ,
        ST_LEN_WAIT,
        ST_SCAN,
        ST_DONE
    } pt_validator_state_t;

    localparam byte_t PT_LEN_ADDR = 8'h00;
    localparam byte_t ASCII_LO    = 8'h20;
    localparam byte_t ASCII_HI    = 8'h7E;

endpackage

// File: rtl/pt_validator_char_range_chk.sv
// Combinational inclusive range comparator: in_range = LO <= ch <= HI (unsigned).
module char_range_chk
    import arc4_pkg::*;
#(
    parameter byte_t LO = ASCII_LO,
    parameter byte_t HI = ASCII_HI
) (
    input  logic [7:0] ch,
    output logic       in_range
);

    assign in_range = (ch >= LO) && (ch <= HI);

endmodule

// File: rtl/pt_validator.sv
// Scans length-prefixed plaintext RAM and flags whether every message byte is in [LO,HI].
// Optional feature macro: PT_VALIDATOR_BAD_ADDR_EN (records index of first bad byte).
module pt_validator
    import arc4_pkg::*;
#(
    parameter byte_t LO = ASCII_LO,
    parameter byte_t HI = ASCII_HI
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       valid,
    output logic [7:0] bad_addr
);

    pt_validator_state_t state_q, state_d;
    logic  rdy_q, rdy_d;
    logic  valid_q, valid_d;
    byte_t pt_addr_q, pt_addr_d;
    byte_t len_q, len_d;
    byte_t k_q, k_d;
    logic  in_range;

`ifdef PT_VALIDATOR_BAD_ADDR_EN
    byte_t bad_addr_q, bad_addr_d;
`endif

    char_range_chk #(.LO(LO), .HI(HI)) u_chk (
        .ch       (pt_rddata),
        .in_range (in_range)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        pt_addr_d = pt_addr_q;
        len_d     = len_q;
        k_d       = k_q;
`ifdef PT_VALIDATOR_BAD_ADDR_EN
        bad_addr_d = bad_addr_q;
`endif
        case (state_q)
            // DONE also accepts en so back-to-back scans lose no cycle.
            ST_IDLE, ST_DONE: begin
                if (en) begin
                    state_d   = ST_LEN_REQ;
                    pt_addr_d = PT_LEN_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN_REQ: begin
                state_d   = ST_LEN_WAIT;
                pt_addr_d = PT_LEN_ADDR + 8'd1;
            end
            ST_LEN_WAIT: begin
                len_d = pt_rddata;
                k_d   = 8'd1;
                if (pt_rddata == 8'd0) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_SCAN;
                    pt_addr_d = pt_addr_q + 8'd1;
                end
            end
            ST_SCAN: begin
                if (!in_range) begin
                    valid_d = 1'b0;
`ifdef PT_VALIDATOR_BAD_ADDR_EN
                    bad_addr_d = k_q;
`endif
                    state_d = ST_DONE;
                end else if (k_q == len_q) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    // Prefetch address may wrap to 0 at L=255; that read is never checked.
                    k_d       = k_q + 8'd1;
                    pt_addr_d = pt_addr_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b1;
            valid_q   <= 1'b0;
            pt_addr_q <= 8'h00;
            len_q     <= 8'h00;
            k_q       <= 8'h00;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            valid_q   <= valid_d;
            pt_addr_q <= pt_addr_d;
            len_q     <= len_d;
            k_q       <= k_d;
        end
    end

`ifdef PT_VALIDATOR_BAD_ADDR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bad_addr_q <= 8'h00;
        else     bad_addr_q <= bad_addr_d;
    end
    assign bad_addr = bad_addr_q;
`else
    assign bad_addr = 8'h00;
`endif

    assign rdy     = rdy_q;
    assign valid   = valid_q;
    assign pt_addr = pt_addr_q;

endmodule

// File: tb/tb_pt_validator.sv
// Directed-vector bench for pt_validator with a behavioural 1-cycle-latency plaintext RAM.
module tb_pt_validator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       valid;
    logic [7:0] bad_addr;

    logic [7:0] mem [256];
    int n_vec  = 0;
    int n_fail = 0;

    pt_validator dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .valid     (valid),
        .bad_addr  (bad_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pt_rddata <= mem[pt_addr];

    // pat: 0 = constant fill, 1 = "HELLO", 2 = alternating 20/7E
    typedef struct {
        int         len;
        int         pat;
        logic [7:0] fill;
        int         bidx;
        logic [7:0] bval;
        logic       exp_valid;
        logic [7:0] exp_bad;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0] eb(input logic [7:0] b);
`ifdef PT_VALIDATOR_BAD_ADDR_EN
        return b;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load(input int len, input int pat, input logic [7:0] fill,
                        input int bidx, input logic [7:0] bval);
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;  // bytes past L are invalid on purpose
        mem[0] = len[7:0];
        for (int i = 1; i <= len; i++) begin
            case (pat)
                1:       mem[i] = hello[i-1];
                2:       mem[i] = (i % 2 == 1) ? 8'h20 : 8'h7E;
                default: mem[i] = fill;
            endcase
        end
        if (bidx != 0) mem[bidx] = bval;
    endtask

    // Called at a negedge with rdy=1; returns just after the accepting edge T.
    task automatic start_scan();
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    // Counts cycles after T until rdy is seen; optional en pulse in cycle pulse_at.
    task automatic wait_rdy(input int pulse_at, output int lat);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            en = (pulse_at != 0 && n == pulse_at);
            if (rdy) begin
                lat = n;
                break;
            end
        end
        en = 1'b0;
        if (lat < 0) $display("FAIL timeout: rdy never rose within 400 cycles");
    endtask

    initial begin
        int lat;
        logic ok;

        vecs[0] = '{0,   0, 8'h41, 0,   8'h00, 1'b1, 8'h00, 3};
        vecs[1] = '{10,  0, 8'h61, 4,   8'h0A, 1'b0, 8'h04, 7};
        vecs[2] = '{5,   1, 8'h00, 0,   8'h00, 1'b1, 8'h04, 8};
        vecs[3] = '{3,   0, 8'h41, 1,   8'h1F, 1'b0, 8'h01, 4};
        vecs[4] = '{255, 2, 8'h00, 0,   8'h00, 1'b1, 8'h01, 258};
        vecs[5] = '{255, 2, 8'h00, 255, 8'h7F, 1'b0, 8'hFF, 258};
        vecs[6] = '{1,   0, 8'h7E, 0,   8'h00, 1'b1, 8'hFF, 4};

        load(0, 0, 8'h00, 0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy",      rdy,      1);
        chk("reset_valid",    valid,    0);
        chk("reset_pt_addr",  pt_addr,  0);
        chk("reset_bad_addr", bad_addr, 0);

        for (int v = 0; v < 7; v++) begin
            load(vecs[v].len, vecs[v].pat, vecs[v].fill, vecs[v].bidx, vecs[v].bval);
            start_scan();
            wait_rdy(0, lat);
            chk($sformatf("vec%0d_latency", v),  lat,      vecs[v].exp_lat);
            chk($sformatf("vec%0d_valid", v),    valid,    vecs[v].exp_valid);
            chk($sformatf("vec%0d_bad_addr", v), bad_addr, eb(vecs[v].exp_bad));
            if (vecs[v].len == 0) chk("empty_last_addr", pt_addr, 1);
        end

        // en pulsed while busy must be dropped, not queued
        load(10, 0, 8'h41, 0, 8'h00);
        start_scan();
        wait_rdy(4, lat);
        chk("busy_en_latency", lat,   13);
        chk("busy_en_valid",   valid, 1);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!rdy) ok = 1'b0;
        end
        chk("busy_en_ignored", ok, 1);

        // reset in the middle of a long scan
        load(200, 0, 8'h41, 0, 8'h00);
        start_scan();
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdy",      rdy,      1);
        chk("midrst_valid",    valid,    0);
        chk("midrst_pt_addr",  pt_addr,  0);
        chk("midrst_bad_addr", bad_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        start_scan();
        wait_rdy(0, lat);
        chk("postrst_latency", lat,   203);
        chk("postrst_valid",   valid, 1);

        // back-to-back: invalid then valid, second accepted in the DONE cycle
        load(3, 0, 8'h61, 2, 8'h0A);
        start_scan();
        wait_rdy(0, lat);
        chk("b2b1_latency", lat,   5);
        chk("b2b1_valid",   valid, 0);
        mem[2] = 8'h61;
        start_scan();
        wait_rdy(0, lat);
        chk("b2b2_latency",  lat,      6);
        chk("b2b2_valid",    valid,    1);
        chk("b2b2_bad_addr", bad_addr, eb(8'h02));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pt_validator.md
# pt_validator

Downstream stage of the ARC4 decrypt core. Once a decryption finishes, this block scans the length-prefixed plaintext memory and decides whether every message byte is printable ASCII. The key-search controller uses it to accept or reject a candidate key, and the top level uses it to drive the "found" LED. It reads the plaintext RAM through a single read port with a registered address and a one-cycle read latency.

## Interface
- LO, default 8'h20: lowest byte value that counts as valid.
- HI, default 8'h7E: highest byte value that counts as valid.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; accepted only in a cycle where rdy=1.
- rdy  out  1  high when idle and able to accept en.
- pt_addr  out  8  registered read address to the plaintext RAM.
- pt_rddata  in  8  RAM data, valid one cycle after pt_addr is presented.
- valid  out  1  result of the last scan: 1 means all message bytes lie within [LO,HI].
- bad_addr  out  8  address of the first offending byte (see Configuration).

## Operation
- Memory layout: pt[0] is the message length L (0..255); the message bytes are pt[1..L].
- States are IDLE, LEN_REQ, LEN_WAIT, SCAN and DONE.
- IDLE: rdy=1. If en=1, go to LEN_REQ and drive pt_addr to 0. Otherwise stay.
- LEN_REQ: wait one cycle for the RAM latency, then go to LEN_WAIT with pt_addr=1.
- LEN_WAIT: latch len=pt_rddata and clear the index k to 1.
  - If len==0: set valid=1 and go to DONE.
  - Otherwise go to SCAN with pt_addr=2. This is a speculative prefetch.
- SCAN: each cycle, check pt_rddata, which is pt[k].
  - Out of range: valid=0, bad_addr=k, go to DONE. This is an early abort.
  - In range and k==len: valid=1, go to DONE.
  - Otherwise: k+1, pt_addr+1.
- DONE: go to IDLE in one cycle, with rdy=1 again.
- The range check is unsigned and inclusive: LO <= byte <= HI.
- pt_addr wraps 8'hFF to 8'h00 during prefetch when L=255. The wrapped read is never checked.
- valid and bad_addr hold until the next accepted scan produces a result. They are not cleared when the scan starts.
- en while rdy=0 is ignored, with no queueing.
- rst asserted mid-scan aborts immediately. Every output and register returns to its reset value.
- Reset values: state=IDLE, rdy=1, pt_addr=0, valid=0, bad_addr=0, len=0, k=0.

## Timing
- en is accepted at edge T, which is the end of cycle T.
- pt_addr=0 during T+1. The length is captured at the end of T+2.
- pt[k] is checked at the end of cycle T+2+k.
- All-valid message of length L: rdy and the new valid are visible in cycle T+3+L.
  - L=0 gives rdy at T+3.
  - L=255 gives rdy at T+258.
- First bad byte at index k: rdy and valid=0 are visible in cycle T+3+k.
- en is accepted again in the first cycle rdy=1, so back-to-back scans lose no extra cycle.
- All outputs are registered. There is no combinational path from en or pt_rddata to any output.

## Configuration
- PT_VALIDATOR_BAD_ADDR_EN
  - Defined: bad_addr records the index of the first failing byte and holds it as described above.
  - Undefined: bad_addr is tied to 8'h00, and its register and comparator are not built. Valid/rdy timing is identical in both builds.

## Structure
- The shared package arc4_pkg holds:
  - the state enum pt_validator_state_t;
  - the constants PT_LEN_ADDR=8'h00, ASCII_LO=8'h20 and ASCII_HI=8'h7E, which are the parameter defaults;
  - the typedef byte_t (logic [7:0]).
- One sub-module, char_range_chk: a purely combinational LO/HI comparator, instanced once in the datapath.

## Test plan
- Reset mid-scan: L=200 all 8'h41; assert rst at T+50 → rdy=1, valid=0, pt_addr=0 next cycle; a fresh scan then passes.
- Empty message: pt[0]=0 → valid=1, rdy at T+3, no read beyond addr 1.
- All printable: pt[0]=5, bytes "HELLO" (48 45 4C 4C 4F) → valid=1, rdy at T+8, bad_addr unchanged.
- Early abort: pt[0]=10, pt[4]=8'h0A, others 8'h61 → valid=0, bad_addr=4 (0 if the macro is undefined), rdy at T+7.
- Boundaries and wrap: L=255 with bytes alternating 8'h20/8'h7E → valid=1, rdy at T+258, pt_addr wraps to 0 without error. Then change the last byte to 8'h7F → valid=0, bad_addr=255.
- Protocol: pulse en while rdy=0 → ignored. Back-to-back scans, first with L=3 invalid and second with L=3 valid → valid goes 0 then 1, and the second scan starts the cycle rdy rises.
